// File: rtl/branch_resolve_unit_pkg.sv
// branch_pkg: counter encodings, FSM states and default sizing for the branch resolve unit
package branch_pkg;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;
  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_e;
  localparam int DEF_ENTRIES = 16;
  localparam int DEF_IDX_W = 4;
  localparam int DEF_FLUSH_CYCLES = 2;
  localparam logic [1:0] DEF_INIT_CTR = WNT;
  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
    return taken ? ((c == ST) ? ST : c + 2'd1) : ((c == SNT) ? SNT : c - 2'd1);
  endfunction
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: EX-stage branch outcome in, redirect/flush back to pipeline control
interface branch_resolve_unit_if;
  logic ex_valid;
  logic ex_is_branch;
  logic ex_pred_taken;
  logic ex_branch_con;
  logic [15:0] ex_pc;
  logic [15:0] ex_pc_plus2;
  logic [15:0] ex_target;
  logic redirect;
  logic [15:0] redirect_pc;
  logic flush;
  modport master (
    output ex_valid, ex_is_branch, ex_pred_taken, ex_branch_con, ex_pc, ex_pc_plus2, ex_target,
    input  redirect, redirect_pc, flush
  );
  modport slave (
    input  ex_valid, ex_is_branch, ex_pred_taken, ex_branch_con, ex_pc, ex_pc_plus2, ex_target,
    output redirect, redirect_pc, flush
  );
endinterface

// File: rtl/bht_counter_array.sv
// bht_counter_array: direct-mapped 2-bit saturating counters, async read, one update port
module bht_counter_array
  import branch_pkg::*;
#(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int IDX_W = DEF_IDX_W,
  parameter logic [1:0] INIT_CTR = DEF_INIT_CTR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  logic [1:0] ctr [ENTRIES];
  assign rd_ctr = ctr[rd_idx];
  // train the indexed counter; a read of the same entry sees the old value until the next cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < ENTRIES; i++) ctr[i] <= INIT_CTR;
    else if (we) ctr[wr_idx] <= sat_update(ctr[wr_idx], wr_taken);
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: trains the BHT from EX outcomes and redirects/flushes on mispredicts
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int IDX_W = DEF_IDX_W,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter logic [1:0] INIT_CTR = DEF_INIT_CTR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           if_pc,
  output logic                  if_pred_taken,
  input  logic                  stall,
  output logic [15:0]           mispredict_cnt,
  branch_resolve_unit_if.slave  ex
);
  state_e state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] redirect_pc_q, redirect_pc_d, mis_cnt, mis_cnt_d;
  logic [1:0] rd_ctr;
  logic resolve, mispredict, unused_bits;
  assign resolve = ex.ex_valid & ex.ex_is_branch & ~stall & (flush_cnt_q == 3'd0);
  assign mispredict = resolve & (ex.ex_pred_taken != ex.ex_branch_con);
  assign unused_bits = ^{if_pc[15:IDX_W+1], if_pc[0], ex.ex_pc[15:IDX_W+1], ex.ex_pc[0], rd_ctr[0]};
  bht_counter_array #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .INIT_CTR(INIT_CTR)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (if_pc[IDX_W:1]),
    .rd_ctr   (rd_ctr),
    .we       (resolve),
    .wr_idx   (ex.ex_pc[IDX_W:1]),
    .wr_taken (ex.ex_branch_con)
  );
  assign if_pred_taken = rd_ctr[1];
  assign ex.redirect = state_q == REDIRECT;
  assign ex.redirect_pc = redirect_pc_q;
  assign ex.flush = flush_cnt_q != 3'd0;
  assign mispredict_cnt = mis_cnt;
  // a mispredict opens REDIRECT and reloads the flush window; stall freezes the whole FSM
  always_comb begin
    flush_cnt_d = stall ? flush_cnt_q : mispredict ? 3'(FLUSH_CYCLES) : (flush_cnt_q != 3'd0) ? flush_cnt_q - 3'd1 : 3'd0;
    state_d = stall ? state_q : mispredict ? REDIRECT : (flush_cnt_d != 3'd0) ? FLUSH : IDLE;
    redirect_pc_d = mispredict ? (ex.ex_branch_con ? ex.ex_target : ex.ex_pc_plus2) : redirect_pc_q;
    mis_cnt_d = (mispredict && mis_cnt != 16'hFFFF) ? mis_cnt + 16'd1 : mis_cnt;
  end
  // state, redirect target and statistics registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      flush_cnt_q <= 3'd0;
      redirect_pc_q <= 16'h0000;
      mis_cnt <= 16'h0000;
    end else begin
      state_q <= state_d;
      flush_cnt_q <= flush_cnt_d;
      redirect_pc_q <= redirect_pc_d;
      mis_cnt <= mis_cnt_d;
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: vector table plus hand sequences, redirect targets checked via scoreboard
module tb_branch_resolve_unit;
  logic clk = 0;
  logic rst = 0;
  logic stall = 0;
  logic [15:0] if_pc = 16'h0004;
  logic if_pred_taken;
  logic [15:0] mispredict_cnt;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];
  branch_resolve_unit_if bi ();
  branch_resolve_unit dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .stall          (stall),
    .mispredict_cnt (mispredict_cnt),
    .ex             (bi.slave)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc, pc2, tgt;
    logic pred, con, redir;
    logic [15:0] rpc;
    logic exp_pred;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t v [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] pc, pc2, tgt, input logic pred, con);
    bi.ex_valid = 1;
    bi.ex_is_branch = 1;
    bi.ex_pc = pc;
    bi.ex_pc_plus2 = pc2;
    bi.ex_target = tgt;
    bi.ex_pred_taken = pred;
    bi.ex_branch_con = con;
    if_pc = pc;
  endtask

  task automatic settle(input int n, output int nred, output int nfl);
    nred = 0;
    nfl = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0) bi.ex_valid = 0;
      nred += int'(bi.redirect);
      nfl += int'(bi.flush);
    end
  endtask

  // scoreboard: every non-stalled redirect cycle consumes one expected target
  always @(negedge clk) begin
    #2;
    if (rst && bi.redirect && !stall) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_redirect: got redirect_pc %0h with nothing expected", bi.redirect_pc);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (bi.redirect_pc !== e) begin
          errors++;
          $display("FAIL redirect_pc: got %0h expected %0h", bi.redirect_pc, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nred, nfl;
    v[0]  = '{16'h0004, 16'h0006, 16'h0040, 1'b0, 1'b1, 1'b1, 16'h0040, 1'b1, 16'd1};
    v[1]  = '{16'h0004, 16'h0006, 16'h0040, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'd1};
    v[2]  = '{16'h0004, 16'h0006, 16'h0040, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'd1};
    v[3]  = '{16'h0004, 16'h0006, 16'h0040, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'd1};
    v[4]  = '{16'h0004, 16'h0006, 16'h0040, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'd1};
    v[5]  = '{16'h0004, 16'h0006, 16'h0040, 1'b1, 1'b0, 1'b1, 16'h0006, 1'b1, 16'd2};
    v[6]  = '{16'h0004, 16'h0006, 16'h0040, 1'b1, 1'b0, 1'b1, 16'h0006, 1'b0, 16'd3};
    v[7]  = '{16'h0004, 16'h0006, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'd3};
    v[8]  = '{16'h0004, 16'h0006, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'd3};
    v[9]  = '{16'h0004, 16'h0006, 16'h0040, 1'b0, 1'b1, 1'b1, 16'h0040, 1'b0, 16'd4};
    v[10] = '{16'h0012, 16'h0014, 16'h0100, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b1, 16'd5};
    bi.ex_valid = 0;
    bi.ex_is_branch = 0;
    bi.ex_pc = 0;
    bi.ex_pc_plus2 = 0;
    bi.ex_target = 0;
    bi.ex_pred_taken = 0;
    bi.ex_branch_con = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_pred", if_pred_taken, 0);
    chk("rst_redirect", bi.redirect, 0);
    chk("rst_flush", bi.flush, 0);
    chk("rst_cnt", mispredict_cnt, 0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(v[i].pc, v[i].pc2, v[i].tgt, v[i].pred, v[i].con);
      if (v[i].redir) exp_q.push_back(v[i].rpc);
      settle(4, nred, nfl);
      chk($sformatf("vec%0d_redirect_cycles", i), nred, v[i].redir ? 1 : 0);
      chk($sformatf("vec%0d_flush_cycles", i), nfl, v[i].redir ? 2 : 0);
      chk($sformatf("vec%0d_pred", i), if_pred_taken, v[i].exp_pred);
      chk($sformatf("vec%0d_cnt", i), mispredict_cnt, v[i].exp_cnt);
    end
    @(negedge clk);
    drive(16'h0004, 16'h0006, 16'h0040, 1, 0);
    exp_q.push_back(16'h0006);
    @(negedge clk);
    bi.ex_valid = 0;
    stall = 1;
    chk("stall_redirect0", bi.redirect, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stall_redirect_held", bi.redirect, 1);
      chk("stall_flush_held", bi.flush, 1);
    end
    @(negedge clk);
    stall = 0;
    chk("stall_redirect_release", bi.redirect, 1);
    @(negedge clk);
    chk("stall_redirect_clear", bi.redirect, 0);
    chk("stall_flush_frozen", bi.flush, 1);
    @(negedge clk);
    chk("stall_flush_done", bi.flush, 0);
    chk("stall_pred", if_pred_taken, 0);
    chk("stall_cnt", mispredict_cnt, 6);
    @(negedge clk);
    stall = 1;
    drive(16'h0012, 16'h0014, 16'h0100, 1, 0);
    repeat (2) @(negedge clk);
    bi.ex_valid = 0;
    stall = 0;
    @(negedge clk);
    chk("stalled_resolve_redirect", bi.redirect, 0);
    chk("stalled_resolve_pred", if_pred_taken, 1);
    chk("stalled_resolve_cnt", mispredict_cnt, 6);
    @(negedge clk);
    drive(16'h0004, 16'h0006, 16'h0040, 0, 1);
    exp_q.push_back(16'h0040);
    @(negedge clk);
    drive(16'h0012, 16'h0014, 16'h0100, 1, 0);
    nred = int'(bi.redirect);
    @(negedge clk);
    nred += int'(bi.redirect);
    @(negedge clk);
    bi.ex_valid = 0;
    nred += int'(bi.redirect);
    @(negedge clk);
    nred += int'(bi.redirect);
    chk("ignore_redirect_cycles", nred, 1);
    chk("ignore_pred_squashed", if_pred_taken, 1);
    if_pc = 16'h0004;
    #1 chk("ignore_pred_first", if_pred_taken, 0);
    chk("ignore_cnt", mispredict_cnt, 7);
    @(negedge clk);
    drive(16'h0012, 16'h0014, 16'h0100, 0, 1);
    exp_q.push_back(16'h0100);
    @(negedge clk);
    bi.ex_valid = 0;
    @(negedge clk);
    chk("midflush_flush", bi.flush, 1);
    rst = 0;
    #1;
    chk("midrst_flush", bi.flush, 0);
    chk("midrst_redirect", bi.redirect, 0);
    chk("midrst_cnt", mispredict_cnt, 0);
    for (int i = 0; i < 16; i++) begin
      if_pc = 16'(i * 2);
      #1 chk($sformatf("midrst_pred%0d", i), if_pred_taken, 0);
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    drive(16'h0012, 16'h0014, 16'h0100, 1, 1);
    settle(3, nred, nfl);
    chk("post_rst_redirect", nred, 0);
    chk("post_rst_wnt_to_wt", if_pred_taken, 1);
    @(negedge clk);
    force dut.mis_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.mis_cnt;
    drive(16'h0004, 16'h0006, 16'h0040, 0, 1);
    exp_q.push_back(16'h0040);
    settle(4, nred, nfl);
    chk("cnt_reach_max", mispredict_cnt, 16'hFFFF);
    @(negedge clk);
    drive(16'h0004, 16'h0006, 16'h0040, 1, 0);
    exp_q.push_back(16'h0006);
    settle(4, nred, nfl);
    chk("cnt_saturate_redirect", nred, 1);
    chk("cnt_saturate", mispredict_cnt, 16'hFFFF);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
